// File: rtl/mem_copy_dma.sv
// mem_copy_dma: word-sequential memory copy engine, one read/latency/write triple per word.
// Defining MEM_COPY_FILL_EN adds a constant-fill mode (fill, fill_value) at one word per cycle.

module mem_copy_dma #(
   parameter int unsigned ADDR_W = 12,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [ADDR_W-1:0] dst_addr,
   input  logic [ADDR_W:0]   len,
`ifdef MEM_COPY_FILL_EN
   input  logic              fill,
   input  logic [DATA_W-1:0] fill_value,
`endif
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   words_done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_read,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   input  logic [DATA_W-1:0] mem_readdata
);

   typedef enum logic [2:0] {StIdle, StRd, StLat, StWr, StFin} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W:0]   rem_q, rem_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   // Last driven address/data, so the memory port holds steady between strobes.
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              accept;
   logic              fill_mode;
   logic [DATA_W-1:0] wr_data;

   assign accept = (state_q == StIdle) && start && (len != '0);

`ifdef MEM_COPY_FILL_EN
   logic              fill_q;
   logic [DATA_W-1:0] fill_val_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fill_q     <= 1'b0;
         fill_val_q <= '0;
      end else if (accept) begin
         fill_q     <= fill;
         fill_val_q <= fill_value;
      end
   end

   assign fill_mode = fill_q;
   assign wr_data   = fill_q ? fill_val_q : data_q;
`else
   assign fill_mode = 1'b0;
   assign wr_data   = data_q;
`endif

   always_comb begin
      state_d       = state_q;
      src_d         = src_q;
      dst_d         = dst_q;
      rem_d         = rem_q;
      cnt_d         = cnt_q;
      data_d        = data_q;
      busy          = (state_q != StIdle);
      done          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_address   = addr_q;
      mem_writedata = wdata_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               cnt_d = '0;
               if (len == '0) begin
                  state_d = StFin;
               end else begin
                  src_d   = src_addr;
                  dst_d   = dst_addr;
                  rem_d   = len;
                  state_d = fill_mode_next() ? StWr : StRd;
               end
            end
         end
         StRd: begin
            mem_read    = 1'b1;
            mem_address = src_q;
            state_d     = StLat;
         end
         StLat: begin
            data_d  = mem_readdata;
            src_d   = src_q + ADDR_W'(1);
            state_d = StWr;
         end
         StWr: begin
            mem_write     = 1'b1;
            mem_address   = dst_q;
            mem_writedata = wr_data;
            dst_d         = dst_q + ADDR_W'(1);
            cnt_d         = cnt_q + (ADDR_W+1)'(1);
            rem_d         = rem_q - (ADDR_W+1)'(1);
            if (rem_q == (ADDR_W+1)'(1)) begin
               state_d = StFin;
            end else begin
               state_d = fill_mode ? StWr : StRd;
            end
         end
         StFin: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Mode requested by the start being accepted this cycle (fill_q is not loaded yet).
   function automatic logic fill_mode_next();
`ifdef MEM_COPY_FILL_EN
      return fill;
`else
      return 1'b0;
`endif
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         addr_q  <= mem_address;
         wdata_q <= mem_writedata;
      end
   end

   assign words_done = cnt_q;

endmodule

// File: tb/tb_mem_copy_dma.sv
// Self-checking bench for mem_copy_dma: registered-read RAM model plus a word-level reference memory.
// Fill-mode scenario is compiled in when MEM_COPY_FILL_EN is defined.

module tb_mem_copy_dma;

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 32;
   localparam int unsigned MEM_WORDS = 4096;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [AW-1:0] dst_addr = '0;
   logic [AW:0]   len = '0;
`ifdef MEM_COPY_FILL_EN
   logic          fill = 1'b0;
   logic [DW-1:0] fill_value = '0;
`endif
   logic          busy, done, mem_read, mem_write;
   logic [AW:0]   words_done;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_writedata;
   logic [DW-1:0] mem_readdata;

   logic [DW-1:0] ram     [MEM_WORDS];
   logic [DW-1:0] ref_mem [MEM_WORDS];
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_a = '0;
   logic [DW-1:0] bd_d = '0;

   int n_checks = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int both_cnt = 0;
   logic [AW-1:0] rd_q[$];
   logic [AW-1:0] wr_q[$];

   always #5 clk = ~clk;

   mem_copy_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .src_addr     (src_addr),
      .dst_addr     (dst_addr),
      .len          (len),
`ifdef MEM_COPY_FILL_EN
      .fill         (fill),
      .fill_value   (fill_value),
`endif
      .busy         (busy),
      .done         (done),
      .words_done   (words_done),
      .mem_address  (mem_address),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_writedata(mem_writedata),
      .mem_readdata (mem_readdata)
   );

   // Synchronous RAM: read data appears the cycle after mem_read; backdoor port for setup.
   always @(posedge clk) begin
      if (mem_read) mem_readdata <= ram[mem_address];
      if (mem_write) ram[mem_address] <= mem_writedata;
      else if (bd_we) ram[bd_a] <= bd_d;
   end

   always @(negedge clk) begin
      if (reset_n) begin
         if (mem_read && mem_write) both_cnt++;
         if (mem_read) rd_q.push_back(mem_address);
         if (mem_write) wr_q.push_back(mem_address);
         if (done) done_cnt++;
      end
   end

   function automatic int mem_diffs();
      int n = 0;
      for (int i = 0; i < MEM_WORDS; i++) if (ram[i] !== ref_mem[i]) n++;
      return n;
   endfunction

   task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bd_we = 1'b1;
      bd_a = a;
      bd_d = d;
      ref_mem[a] = d;
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   // Reference: ascending word-by-word copy, addresses modulo 2^AW.
   task automatic model_copy(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int n);
      for (int i = 0; i < n; i++) begin
         logic [AW-1:0] s, d;
         s = src + AW'(i);
         d = dst + AW'(i);
         ref_mem[d] = ref_mem[s];
      end
   endtask

   // Called at a negedge; lat is the cycle (start-accept cycle = 0) in which done is seen.
   task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                           input int poke, output int lat, output int wd);
      src_addr = s;
      dst_addr = d;
      len = (AW+1)'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 2000) begin
         if (lat == poke) begin
            start = 1'b1;
            src_addr = AW'($urandom);
            dst_addr = AW'($urandom);
            len = (AW+1)'(1);
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      wd = int'(words_done);
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({busy, done, mem_read, mem_write} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_strobes: busy/done/rd/wr=%b expected 0000",
                  {busy, done, mem_read, mem_write});
      end
      n_checks++;
      if (words_done !== '0) begin
         n_fail++;
         $display("FAIL reset_words_done: got %0d expected 0", words_done);
      end
      n_checks++;
      if (mem_address !== '0 || mem_writedata !== '0) begin
         n_fail++;
         $display("FAIL reset_mem_port: addr=%h data=%h expected 0/0", mem_address, mem_writedata);
      end
   endtask

   task automatic init_ram();
      @(negedge clk);
      for (int i = 0; i < MEM_WORDS; i++) bd_write(AW'(i), $urandom);
   endtask

   // Reset is released here so the first start lands on the first edge after release.
   task automatic test_copy();
      int lat, wd;
      for (int i = 0; i < 4; i++) bd_write(AW'(12'h010 + i), 32'hA000_0000 + i);
      reset_n = 1'b1;
      run_copy(12'h010, 12'h100, 4, 0, lat, wd);
      model_copy(12'h010, 12'h100, 4);
      n_checks++;
      if (lat !== 3 * 4 + 1) begin
         n_fail++;
         $display("FAIL copy_latency: done at cycle %0d expected %0d", lat, 3 * 4 + 1);
      end
      n_checks++;
      if (wd !== 4) begin
         n_fail++;
         $display("FAIL copy_words_done: got %0d expected 4", wd);
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (ram[12'h100 + i] !== 32'hA000_0000 + i) begin
            n_fail++;
            $display("FAIL copy_word%0d: got %h expected %h", i, ram[12'h100 + i],
                     32'hA000_0000 + i);
         end
      end
      n_checks++;
      if (mem_diffs() !== 0) begin
         n_fail++;
         $display("FAIL copy_memory: %0d words differ expected 0", mem_diffs());
      end
   endtask

   task automatic test_len0();
      int lat, wd, r0, w0;
      r0 = rd_q.size();
      w0 = wr_q.size();
      run_copy(12'h055, 12'h066, 0, 0, lat, wd);
      n_checks++;
      if (lat !== 1) begin
         n_fail++;
         $display("FAIL len0_latency: done at cycle %0d expected 1", lat);
      end
      n_checks++;
      if (rd_q.size() !== r0 || wr_q.size() !== w0) begin
         n_fail++;
         $display("FAIL len0_no_access: reads %0d writes %0d expected 0/0",
                  rd_q.size() - r0, wr_q.size() - w0);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL len0_idle: busy=%b expected 0", busy);
      end
   endtask

   task automatic test_wrap();
      int lat, wd, r0, w0;
      r0 = rd_q.size();
      w0 = wr_q.size();
      run_copy(12'hFFE, 12'h7FE, 4, 0, lat, wd);
      model_copy(12'hFFE, 12'h7FE, 4);
      n_checks++;
      if (rd_q.size() - r0 !== 4 || wr_q.size() - w0 !== 4) begin
         n_fail++;
         $display("FAIL wrap_counts: reads %0d writes %0d expected 4/4",
                  rd_q.size() - r0, wr_q.size() - w0);
      end else begin
         for (int i = 0; i < 4; i++) begin
            logic [AW-1:0] ea, eb;
            ea = 12'hFFE + AW'(i);
            eb = 12'h7FE + AW'(i);
            n_checks++;
            if (rd_q[r0 + i] !== ea || wr_q[w0 + i] !== eb) begin
               n_fail++;
               $display("FAIL wrap_addr%0d: rd %h wr %h expected %h %h", i, rd_q[r0 + i],
                        wr_q[w0 + i], ea, eb);
            end
         end
      end
      n_checks++;
      if (mem_diffs() !== 0) begin
         n_fail++;
         $display("FAIL wrap_memory: %0d words differ expected 0", mem_diffs());
      end
   endtask

   task automatic test_busy_overlap();
      int lat, wd, d0;
      logic [DW-1:0] x;
      for (int i = 0; i < 4; i++) bd_write(AW'(12'h020 + i), $urandom);
      x = ref_mem[12'h020];
      d0 = done_cnt;
      run_copy(12'h020, 12'h021, 3, 4, lat, wd);
      model_copy(12'h020, 12'h021, 3);
      repeat (3) @(negedge clk);
      n_checks++;
      if (lat !== 3 * 3 + 1 || wd !== 3) begin
         n_fail++;
         $display("FAIL overlap_timing: done at %0d words %0d expected 10/3", lat, wd);
      end
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (ram[12'h021 + i] !== x) begin
            n_fail++;
            $display("FAIL overlap_word%0d: got %h expected %h", i, ram[12'h021 + i], x);
         end
      end
      n_checks++;
      if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_start_ignored: dones %0d busy %b expected 1/0", done_cnt - d0, busy);
      end
      n_checks++;
      if (mem_diffs() !== 0) begin
         n_fail++;
         $display("FAIL overlap_memory: %0d words differ expected 0", mem_diffs());
      end
   endtask

   task automatic test_reset_abort();
      int k, ch, d0, lat, wd;
      for (int i = 0; i < 8; i++) bd_write(AW'(12'h200 + i), 32'h5A00_0000 + i);
      for (int i = 0; i < 8; i++) bd_write(AW'(12'h300 + i), 32'hC300_0000 + i);
      d0 = done_cnt;
      src_addr = 12'h200;
      dst_addr = 12'h300;
      len = 13'd8;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (words_done !== 13'd2 && k < 100) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (k >= 100) begin
         n_fail++;
         $display("FAIL abort_wait: words_done=%0d expected to reach 2", words_done);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, done, mem_read, mem_write} !== 4'b0000 || words_done !== '0 ||
          mem_address !== '0 || mem_writedata !== '0) begin
         n_fail++;
         $display("FAIL abort_outputs: busy %b done %b rd %b wr %b wd %0d addr %h expected all 0",
                  busy, done, mem_read, mem_write, words_done, mem_address);
      end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_copy(12'h200, 12'h300, 2);
      ch = 0;
      for (int i = 0; i < 8; i++) if (ram[12'h300 + i] !== 32'hC300_0000 + i) ch++;
      n_checks++;
      if (ch !== 2) begin
         n_fail++;
         $display("FAIL abort_words_changed: got %0d expected 2", ch);
      end
      n_checks++;
      if (done_cnt !== d0) begin
         n_fail++;
         $display("FAIL abort_no_done: dones %0d expected 0", done_cnt - d0);
      end
      run_copy(12'h210, 12'h310, 1, 0, lat, wd);
      model_copy(12'h210, 12'h310, 1);
      n_checks++;
      if (lat !== 4 || wd !== 1) begin
         n_fail++;
         $display("FAIL abort_restart: done at %0d words %0d expected 4/1", lat, wd);
      end
      n_checks++;
      if (mem_diffs() !== 0) begin
         n_fail++;
         $display("FAIL abort_memory: %0d words differ expected 0", mem_diffs());
      end
   endtask

`ifdef MEM_COPY_FILL_EN
   task automatic test_fill();
      int lat, wd, r0;
      r0 = rd_q.size();
      fill = 1'b1;
      fill_value = 32'hDEAD_BEEF;
      run_copy(12'h123, 12'h040, 5, 0, lat, wd);
      fill = 1'b0;
      for (int i = 0; i < 5; i++) ref_mem[12'h040 + i] = 32'hDEAD_BEEF;
      n_checks++;
      if (lat !== 5 + 1 || wd !== 5) begin
         n_fail++;
         $display("FAIL fill_timing: done at %0d words %0d expected 6/5", lat, wd);
      end
      n_checks++;
      if (rd_q.size() !== r0) begin
         n_fail++;
         $display("FAIL fill_no_reads: reads %0d expected 0", rd_q.size() - r0);
      end
      n_checks++;
      if (mem_diffs() !== 0) begin
         n_fail++;
         $display("FAIL fill_memory: %0d words differ expected 0", mem_diffs());
      end
   endtask
`endif

   task automatic test_random();
      int lat, wd, n;
      logic [AW-1:0] s, d;
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(1, 12);
         s = AW'($urandom);
         d = AW'($urandom);
         run_copy(s, d, n, 0, lat, wd);
         model_copy(s, d, n);
         n_checks++;
         if (lat !== 3 * n + 1 || wd !== n) begin
            n_fail++;
            $display("FAIL random%0d_timing: done at %0d words %0d expected %0d/%0d", it, lat, wd,
                     3 * n + 1, n);
         end
         n_checks++;
         if (mem_diffs() !== 0) begin
            n_fail++;
            $display("FAIL random%0d_memory: src %h dst %h len %0d, %0d words differ", it, s, d, n,
                     mem_diffs());
         end
      end
   endtask

   task automatic test_strobes();
      n_checks++;
      if (both_cnt !== 0) begin
         n_fail++;
         $display("FAIL strobe_exclusive: %0d cycles with read and write expected 0", both_cnt);
      end
   endtask

   initial begin
      test_reset();
      init_ram();
      test_copy();
      test_len0();
      test_wrap();
      test_busy_overlap();
      test_reset_abort();
`ifdef MEM_COPY_FILL_EN
      test_fill();
`endif
      test_random();
      test_strobes();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_copy_dma.md
MEM_COPY_DMA -- requirements
Module: mem_copy_dma

Interface
REQ-001 Parameter ADDR_W, default 12, SHALL set the word-address width of the memory port and of the source and destination address inputs.
REQ-002 Parameter DATA_W, default 32, SHALL set the memory data width.
REQ-003 Port clk, input, 1: SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port reset_n, input, 1: SHALL be an asynchronous, active-low reset.
REQ-005 Port start, input, 1: SHALL request a transfer, sampled only in IDLE.
REQ-006 Port src_addr, input, ADDR_W: SHALL give the first source word address, captured on an accepted start.
REQ-007 Port dst_addr, input, ADDR_W: SHALL give the first destination word address, captured on an accepted start.
REQ-008 Port len, input, ADDR_W+1: SHALL give the word count, 0..4096, captured on an accepted start.
REQ-009 Port busy, output, 1: SHALL be high whenever the state is not IDLE.
REQ-010 Port done, output, 1: SHALL pulse high for one cycle when a transfer ends.
REQ-011 Port words_done, output, ADDR_W+1: SHALL give the count of words written in the current or last transfer.
REQ-012 Port mem_address, output, ADDR_W: SHALL drive the memory word address.
REQ-013 Ports mem_read and mem_write, output, 1 each: SHALL be the memory read and write strobes, never both high in the same cycle.
REQ-014 Port mem_writedata, output, DATA_W: SHALL drive the memory write data.
REQ-015 Port mem_readdata, input, DATA_W: SHALL carry the memory read data, registered by the memory and valid in the cycle after mem_read.

Function
REQ-016 States SHALL be IDLE, RD, LAT, WR and FIN.
REQ-017 In IDLE, start=1 with len>0 SHALL capture src_addr, dst_addr and len, clear words_done, and go to RD.
REQ-018 In IDLE, start=1 with len=0 SHALL go directly to FIN with no memory access.
REQ-019 In RD, the block SHALL drive mem_read=1 with mem_address=src pointer, then go to LAT.
REQ-020 In LAT, the block SHALL drive no strobe, capture mem_readdata into the data register, increment the src pointer, and go to WR.
REQ-021 In WR, the block SHALL drive mem_write=1, mem_address=dst pointer and mem_writedata=data register.
REQ-022 In WR, the block SHALL also increment the dst pointer, increment words_done, and decrement the remaining count.
REQ-023 From WR, the block SHALL go to RD if the remaining count is nonzero, otherwise to FIN.
REQ-024 In FIN, the block SHALL assert done=1 for exactly one cycle and return to IDLE; busy is high in FIN.
REQ-025 Throughput SHALL be 3 cycles per word.
REQ-026 For len=N>0, done SHALL be asserted 3N+1 cycles after the cycle in which start is accepted.
REQ-027 Pointers SHALL wrap modulo 2^ADDR_W (address 4095 is followed by 0).
REQ-028 start while busy SHALL be ignored with no effect.
REQ-029 Copy order SHALL be ascending and word-sequential; overlapping regions SHALL yield exactly the word-by-word sequential result.
REQ-030 Outside RD and WR, mem_read=0 and mem_write=0; mem_address and mem_writedata hold their last values.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, mem_read=0, mem_write=0, words_done=0, mem_address=0 and mem_writedata=0, all pointers and the data register to 0.
REQ-032 Reset mid-transfer SHALL abort the transfer without a done pulse; words already written remain in memory.
REQ-033 The first start SHALL be accepted on the first rising edge after reset_n deasserts.

Configuration
REQ-034 With MEM_COPY_FILL_EN defined, input fill (1) and input fill_value (DATA_W) SHALL exist, captured on an accepted start.
REQ-035 With MEM_COPY_FILL_EN defined and fill=1, the block SHALL skip RD and LAT, writing fill_value to len consecutive dst words at 1 word per cycle in WR, so done follows N+1 cycles after start.
REQ-036 Without MEM_COPY_FILL_EN, the fill and fill_value ports SHALL be absent and only copy mode SHALL exist.

Verification
REQ-037 Bench SHALL cover copy: RAM words 0x10..0x13 = A0,A1,A2,A3; start src=0x10, dst=0x100, len=4 -> 0x100..0x103 = A0..A3, done at cycle 13, words_done=4.
REQ-038 Bench SHALL cover len=0: start len=0 -> done on the next cycle, with mem_read and mem_write never asserted.
REQ-039 Bench SHALL cover wrap: src=0xFFE, dst=0x7FE, len=4 -> reads 0xFFE,0xFFF,0x000,0x001 and writes 0x7FE..0x801.
REQ-040 Bench SHALL cover reset: reset_n pulsed low after 2 words of len=8 -> busy=0 immediately, no done, exactly 2 destination words changed, and a new start is accepted afterwards.
REQ-041 Bench SHALL cover start-while-busy and overlap: a second start mid-transfer is ignored; src=0x20, dst=0x21, len=3 with words X,Y,Z,W -> 0x21..0x23 = X,X,X.
REQ-042 Bench SHALL cover fill with MEM_COPY_FILL_EN: fill=1, fill_value=0xDEADBEEF, dst=0x40, len=5 -> 0x40..0x44 = 0xDEADBEEF, done 6 cycles after start, and no reads.
